// File: rtl/mux_2.sv
// Two-lane W-bit mux: combinational output, qualified registered output and a
// saturating select-change counter. Define MUX_2_PARITY_EN to add o_par.
module mux_2 #(
   parameter int W     = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2*W-1:0]   i,
   input  logic             s,
   input  logic             in_vld,
   output logic [W-1:0]     o,
   output logic [W-1:0]     o_q,
   output logic             out_vld,
`ifdef MUX_2_PARITY_EN
   output logic             o_par,
`endif
   output logic [CNT_W-1:0] sel_chg_cnt
);

`ifdef MUX_2_PARITY_EN
   function automatic logic even_par(input logic [W-1:0] d);
      return ^d;
   endfunction
`endif

   logic [W-1:0]     lane0_s;
   logic [W-1:0]     lane1_s;
   logic [W-1:0]     sel_s;
   logic             s_last_r;
   logic             seen_r;
   logic             cnt_max_s;
   logic             cnt_inc_s;

   assign lane0_s = i[W-1:0];
   assign lane1_s = i[2*W-1:W];

   // Lane selection; the unselected lane never reaches the result.
   always_comb begin
      sel_s = lane0_s;
      if (s == 1'b1) begin
         sel_s = lane1_s;
      end else begin
         sel_s = lane0_s;
      end
   end

   assign o = sel_s;

   // A change counts only once a prior qualified sample exists to compare against.
   always_comb begin
      cnt_max_s = (sel_chg_cnt == {CNT_W{1'b1}});
      cnt_inc_s = 1'b0;
      if (seen_r && (s != s_last_r) && !cnt_max_s) begin
         cnt_inc_s = 1'b1;
      end else begin
         cnt_inc_s = 1'b0;
      end
   end

   // Registered path, select history and change counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_q         <= {W{1'b0}};
         out_vld     <= 1'b0;
         s_last_r    <= 1'b0;
         seen_r      <= 1'b0;
         sel_chg_cnt <= {CNT_W{1'b0}};
`ifdef MUX_2_PARITY_EN
         o_par       <= 1'b0;
`endif
      end else if (in_vld) begin
         o_q      <= sel_s;
         out_vld  <= 1'b1;
         s_last_r <= s;
         seen_r   <= 1'b1;
`ifdef MUX_2_PARITY_EN
         o_par    <= even_par(sel_s);
`endif
         if (cnt_inc_s) begin
            sel_chg_cnt <= sel_chg_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            sel_chg_cnt <= sel_chg_cnt;
         end
      end else begin
         out_vld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_2.sv
// Directed self-checking bench for mux_2: default, CNT_W=2 and W=4 instances.
module tb_mux_2;

   logic        clk;
   logic        rst;
   logic [1:0]  i1;
   logic [7:0]  i4;
   logic        s;
   logic        in_vld;

   logic        o1, oq1, vld1;
   logic [15:0] cnt1;
   logic        o_sat, oq_sat, vld_sat;
   logic [1:0]  cnt_sat;
   logic [3:0]  o4, oq4;
   logic        vld4;
   logic [15:0] cnt4;
`ifdef MUX_2_PARITY_EN
   logic        par1, par_sat, par4;
`endif

   int checks_total;
   int errors;

   mux_2 #(.W(1), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .i(i1), .s(s), .in_vld(in_vld),
      .o(o1), .o_q(oq1), .out_vld(vld1),
`ifdef MUX_2_PARITY_EN
      .o_par(par1),
`endif
      .sel_chg_cnt(cnt1));

   mux_2 #(.W(1), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .i(i1), .s(s), .in_vld(in_vld),
      .o(o_sat), .o_q(oq_sat), .out_vld(vld_sat),
`ifdef MUX_2_PARITY_EN
      .o_par(par_sat),
`endif
      .sel_chg_cnt(cnt_sat));

   mux_2 #(.W(4), .CNT_W(16)) u_w4 (
      .clk(clk), .rst(rst), .i(i4), .s(s), .in_vld(in_vld),
      .o(o4), .o_q(oq4), .out_vld(vld4),
`ifdef MUX_2_PARITY_EN
      .o_par(par4),
`endif
      .sel_chg_cnt(cnt4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic sq [5];
      checks_total = 0;
      errors       = 0;
      rst    = 1'b1;
      in_vld = 1'b0;
      s      = 1'b0;
      i1     = 2'b00;
      i4     = 8'h00;

      // Reset state, with o still combinational during reset
      tick();
      i1 = 2'b10; s = 1'b1;
      tick();
      check("rst_oq",  oq1,  1'b0);
      check("rst_vld", vld1, 1'b0);
      check("rst_cnt", cnt1, 16'd0);
      check("rst_o_comb", o1, 1'b1);

      // Combinational mux, not clocked
      rst = 1'b0;
      i1 = 2'b01; s = 1'b1; #10; check("o_01_1", o1, 1'b0);
      i1 = 2'b10; s = 1'b1; #10; check("o_10_1", o1, 1'b1);
      i1 = 2'b01; s = 1'b0; #10; check("o_01_0", o1, 1'b1);
      i1 = 2'b10; s = 1'b0; #10; check("o_10_0", o1, 1'b0);

      // Registered path: load then hold
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      i1 = 2'b10; s = 1'b1; in_vld = 1'b1;
      tick();
      check("load_oq",  oq1,  1'b1);
      check("load_vld", vld1, 1'b1);
      check("first_no_count", cnt1, 16'd0);
      in_vld = 1'b0; s = 1'b0;
      tick();
      check("hold_oq",  oq1,  1'b1);
      check("hold_vld", vld1, 1'b0);

      // Counter: 0,1,1,0,1 gives 3 changes
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      sq[0] = 1'b0; sq[1] = 1'b1; sq[2] = 1'b1; sq[3] = 1'b0; sq[4] = 1'b1;
      in_vld = 1'b1;
      for (int k = 0; k < 5; k++) begin
         s = sq[k];
         tick();
      end
      check("cnt_seq",     cnt1,    16'd3);
      check("cnt_sat_seq", cnt_sat, 2'd3);
      in_vld = 1'b0;
      s = 1'b0; tick();
      s = 1'b1; tick();
      check("cnt_unqual", cnt1, 16'd3);
      in_vld = 1'b1;
      s = 1'b0; tick();
      s = 1'b1; tick();
      check("cnt_five",     cnt1,    16'd5);
      check("cnt_sat_hold", cnt_sat, 2'd3);

      // Unknown on unselected lane
      i1 = {1'bx, 1'b1}; s = 1'b0; #1;
      check("x_hi_o", o1, 1'b1);
      tick();
      check("x_hi_oq", oq1, 1'b1);
      i1 = {1'b0, 1'bx}; s = 1'b1; #1;
      check("x_lo_o", o1, 1'b0);
      tick();
      check("x_lo_oq", oq1, 1'b0);

      // Reset mid-stream discards pending sample
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      i1 = 2'b10; in_vld = 1'b1;
      s = 1'b0; tick();
      s = 1'b1; tick();
      s = 1'b0; tick();
      check("cnt_two", cnt1, 16'd2);
      s = 1'b1; rst = 1'b1;
      tick();
      check("mid_rst_oq",  oq1,  1'b0);
      check("mid_rst_vld", vld1, 1'b0);
      check("mid_rst_cnt", cnt1, 16'd0);
      rst = 1'b0;
      tick();
      check("post_rst_oq",  oq1,  1'b1);
      check("post_rst_cnt", cnt1, 16'd0);

      // W=4 lanes and parity
      i4 = 8'hA5; s = 1'b0; in_vld = 1'b1; #1;
      check("w4_o_lo", o4, 4'h5);
      tick();
      check("w4_oq_lo", oq4, 4'h5);
`ifdef MUX_2_PARITY_EN
      check("par_5", par4, 1'b0);
`endif
      s = 1'b1; #1;
      check("w4_o_hi", o4, 4'hA);
      tick();
      check("w4_oq_hi", oq4, 4'hA);
`ifdef MUX_2_PARITY_EN
      check("par_a", par4, 1'b0);
`endif
      i4 = 8'h17; s = 1'b0;
      tick();
      check("w4_oq_7", oq4, 4'h7);
`ifdef MUX_2_PARITY_EN
      check("par_7", par4, 1'b1);
      in_vld = 1'b0; i4 = 8'h10;
      tick();
      check("par_hold", par4, 1'b1);
      rst = 1'b1;
      tick();
      check("par_rst", par4, 1'b0);
      rst = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks_total);
      $finish;
   end

endmodule

// File: doc/mux_2.md
MUX_2 -- requirements
Module: mux_2

Interface
REQ-001 Parameter W, default 1, data width of each input lane (W >= 1).
REQ-002 Parameter CNT_W, default 16, width of the select-change counter (CNT_W >= 2).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 i  input  2*W  packed inputs; lane 0 = i[W-1:0], lane 1 = i[2*W-1:W].
REQ-006 s  input  1  select; 0 picks lane 0, 1 picks lane 1.
REQ-007 in_vld  input  1  qualifies i and s for the registered path and the counter.
REQ-008 o  output  W  combinational mux result.
REQ-009 o_q  output  W  registered mux result.
REQ-010 out_vld  output  1  marks o_q as valid.
REQ-011 sel_chg_cnt  output  CNT_W  saturating count of qualified select changes.

Function
REQ-012 o SHALL equal lane s of i at all times, with zero latency and no dependence on clk, rst or in_vld.
- i=2'b01, s=1 -> o=0.
- i=2'b10, s=1 -> o=1.
- i=2'b01, s=0 -> o=1.
- i=2'b10, s=0 -> o=0.
REQ-013 On each rising clk edge with rst=0 and in_vld=1, o_q SHALL load lane s of i and out_vld SHALL go to 1.
- Latency from qualified input to o_q is exactly 1 cycle.
REQ-014 On a rising clk edge with rst=0 and in_vld=0, o_q SHALL hold its value and out_vld SHALL go to 0.
REQ-015 An internal register s_last SHALL capture s on every qualified cycle.
REQ-016 sel_chg_cnt SHALL increment by 1 on a qualified cycle only when s differs from s_last and a prior qualified cycle has occurred since reset.
- The first qualified cycle after reset SHALL NOT count.
REQ-017 sel_chg_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 X or Z on the unselected lane SHALL NOT affect o or o_q.

Reset
REQ-019 While rst=1 at a rising edge, the following SHALL all clear to 0, overriding in_vld:
- o_q
- out_vld
- sel_chg_cnt
- s_last
- the prior-qualified flag
REQ-020 Asserting rst mid-stream SHALL discard the pending sample.
- out_vld is 0 in the cycle after the reset edge.
REQ-021 o SHALL remain purely combinational during reset.

Configuration
REQ-022 Macro MUX_2_PARITY_EN SHALL add output o_par (1 bit), registered alongside o_q.
- o_par is the even parity (XOR reduction) of the selected lane.
- o_par updates with the same qualification rules as o_q.
- o_par clears to 0 on reset.
REQ-023 Without MUX_2_PARITY_EN, port o_par and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-024 W=1: drive i/s = 01/1, 10/1, 01/0, 10/0 for 10 time units each -> o = 0, 1, 1, 0.
REQ-025 rst=1 for 2 cycles, then in_vld=1 with i=2'b10, s=1 -> next cycle o_q=1, out_vld=1; in_vld=0 -> o_q holds 1, out_vld=0.
REQ-026 Qualified s sequence 0,1,1,0,1 -> sel_chg_cnt=3; CNT_W=2 with 5 changes -> sel_chg_cnt stays 3.
REQ-027 Assert rst during a qualified stream with sel_chg_cnt=2 -> the next cycle shows o_q=0, out_vld=0, sel_chg_cnt=0.
REQ-028 W=4, i=8'hA5: s=0 -> o=4'h5, s=1 -> o=4'hA; with MUX_2_PARITY_EN, one cycle after each qualified input -> o_par=0.
